// File: rtl/noc_core_adapter.sv
// noc_core_adapter
// Bridges a processing core to a NoC router port.
//   Injection: per-VC FIFOs written by the core, drained by a round-robin
//   arbiter that keeps a VC locked until the tail flit of its packet is sent.
//   Ejection:  per-VC FIFOs filled by the router, read by the core one VC
//   at a time with a registered data output.
// Optional build macro: NOC_ADAPTER_STATS_EN adds saturating 16-bit counters
//   inj_count (flits sent to the router) and ej_count (flits given to the core).
module noc_core_adapter #(
    parameter int DATA_WIDTH      = 32,
    parameter int VC_BITS         = 1,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          c_WEn,
    input  logic [DATA_WIDTH-1:0]         core_data_in,
    input  logic [VC_BITS-1:0]            core_vc_in,
    input  logic                          core_tail_in,
    output logic [(32'd1<<VC_BITS)-1:0]   core_full_out,
    output logic [DATA_WIDTH-1:0]         r_flits_out,
    output logic [VC_BITS-1:0]            r_vc_out,
    output logic                          r_tail_out,
    output logic                          r_valid_out,
    input  logic [(32'd1<<VC_BITS)-1:0]   r_full_in,
    input  logic [DATA_WIDTH-1:0]         r_flits_in,
    input  logic [VC_BITS-1:0]            r_vc_in,
    input  logic                          r_valid_in,
    output logic [(32'd1<<VC_BITS)-1:0]   r_full_out,
    input  logic                          c_REn,
    input  logic [VC_BITS-1:0]            core_vc_sel,
    output logic [DATA_WIDTH-1:0]         core_data_out,
    output logic                          core_valid_out,
    output logic [(32'd1<<VC_BITS)-1:0]   core_empty_out
`ifdef NOC_ADAPTER_STATS_EN
    ,
    output logic [15:0]                   inj_count,
    output logic [15:0]                   ej_count
`endif
);

    localparam int NUM_VCS = 32'd1 << VC_BITS;
    localparam int DEPTH   = 32'd1 << FIFO_DEPTH_BITS;
    localparam int CNT_W   = FIFO_DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } inj_state_t;

    // Injection storage: bit DATA_WIDTH carries the tail marker
    logic [DATA_WIDTH:0]          r_inj_mem [NUM_VCS][DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]   r_inj_wr  [NUM_VCS];
    logic [FIFO_DEPTH_BITS-1:0]   r_inj_rd  [NUM_VCS];
    logic [CNT_W-1:0]             r_inj_cnt [NUM_VCS];

    logic [DATA_WIDTH-1:0]        r_ej_mem  [NUM_VCS][DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]   r_ej_wr   [NUM_VCS];
    logic [FIFO_DEPTH_BITS-1:0]   r_ej_rd   [NUM_VCS];
    logic [CNT_W-1:0]             r_ej_cnt  [NUM_VCS];

    logic [NUM_VCS-1:0] w_inj_full;
    logic [NUM_VCS-1:0] w_inj_empty;
    logic [NUM_VCS-1:0] w_elig;
    logic [NUM_VCS-1:0] w_inj_push;
    logic [NUM_VCS-1:0] w_inj_pop;
    logic [NUM_VCS-1:0] w_ej_full;
    logic [NUM_VCS-1:0] w_ej_empty;
    logic [NUM_VCS-1:0] w_ej_push;
    logic [NUM_VCS-1:0] w_ej_pop;

    inj_state_t           r_state;
    inj_state_t           w_state_nxt;
    logic [VC_BITS-1:0]   r_lock_vc;
    logic [VC_BITS-1:0]   w_lock_nxt;
    logic [VC_BITS-1:0]   r_rr_ptr;     // first VC examined by the next IDLE search
    logic [VC_BITS-1:0]   w_scan_vc;
    logic [VC_BITS-1:0]   w_grant_vc;
    logic                 w_grant;
    logic [DATA_WIDTH:0]  w_inj_head;
    logic [DATA_WIDTH-1:0] w_ej_head;

    assign core_full_out  = w_inj_full;
    assign r_full_out     = w_ej_full;
    assign core_empty_out = w_ej_empty;
    assign w_inj_head     = r_inj_mem[w_grant_vc][r_inj_rd[w_grant_vc]];
    assign w_ej_head      = r_ej_mem[core_vc_sel][r_ej_rd[core_vc_sel]];

    // Per-VC full/empty flags from the occupancy counters, plus eligibility
    always_comb begin
        w_inj_full  = '0;
        w_inj_empty = '0;
        w_elig      = '0;
        w_ej_full   = '0;
        w_ej_empty  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_inj_full[v]  = (r_inj_cnt[v] == FULL_CNT);
            w_inj_empty[v] = (r_inj_cnt[v] == '0);
            w_elig[v]      = !w_inj_empty[v] && !r_full_in[v];
            w_ej_full[v]   = (r_ej_cnt[v] == FULL_CNT);
            w_ej_empty[v]  = (r_ej_cnt[v] == '0);
        end
    end

    // Injection arbiter: round-robin in IDLE, single-VC service while LOCKED
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_vc;
        w_grant     = 1'b0;
        w_grant_vc  = r_lock_vc;
        w_scan_vc   = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                for (int i = 0; i < NUM_VCS; i++) begin
                    w_scan_vc = r_rr_ptr + VC_BITS'(i);
                    if (!w_grant && w_elig[w_scan_vc]) begin
                        w_grant    = 1'b1;
                        w_grant_vc = w_scan_vc;
                    end else begin
                        w_grant    = w_grant;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_elig[r_lock_vc]) begin
                    w_grant    = 1'b1;
                    w_grant_vc = r_lock_vc;
                end else begin
                    w_grant    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_grant) begin
            w_lock_nxt  = w_grant_vc;
            w_state_nxt = r_inj_mem[w_grant_vc][r_inj_rd[w_grant_vc]][DATA_WIDTH] ?
                          ST_IDLE : ST_LOCKED;
        end else begin
            w_lock_nxt  = r_lock_vc;
        end
    end

    // Push/pop decode; a pop on a full FIFO frees the slot for a same-cycle push
    always_comb begin
        w_inj_pop  = '0;
        w_inj_push = '0;
        w_ej_pop   = '0;
        w_ej_push  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_inj_pop[v]  = w_grant && (w_grant_vc == VC_BITS'(v));
            w_ej_pop[v]   = c_REn && (core_vc_sel == VC_BITS'(v)) && !w_ej_empty[v];
            w_inj_push[v] = c_WEn && (core_vc_in == VC_BITS'(v)) &&
                            (!w_inj_full[v] || w_inj_pop[v]);
            w_ej_push[v]  = r_valid_in && (r_vc_in == VC_BITS'(v)) &&
                            (!w_ej_full[v] || w_ej_pop[v]);
        end
    end

    // FIFO payload storage (contents need no reset; occupancy guards reads)
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++) begin
            if (w_inj_push[v]) begin
                r_inj_mem[v][r_inj_wr[v]] <= {core_tail_in, core_data_in};
            end
            if (w_ej_push[v]) begin
                r_ej_mem[v][r_ej_wr[v]] <= r_flits_in;
            end
        end
    end

    // Injection FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_inj_wr[v]  <= '0;
                r_inj_rd[v]  <= '0;
                r_inj_cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_inj_push[v]) r_inj_wr[v] <= r_inj_wr[v] + 1'b1;
                if (w_inj_pop[v])  r_inj_rd[v] <= r_inj_rd[v] + 1'b1;
                r_inj_cnt[v] <= r_inj_cnt[v] + CNT_W'(w_inj_push[v]) - CNT_W'(w_inj_pop[v]);
            end
        end
    end

    // Ejection FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_ej_wr[v]  <= '0;
                r_ej_rd[v]  <= '0;
                r_ej_cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_ej_push[v]) r_ej_wr[v] <= r_ej_wr[v] + 1'b1;
                if (w_ej_pop[v])  r_ej_rd[v] <= r_ej_rd[v] + 1'b1;
                r_ej_cnt[v] <= r_ej_cnt[v] + CNT_W'(w_ej_push[v]) - CNT_W'(w_ej_pop[v]);
            end
        end
    end

    // Arbiter state, locked VC and round-robin start pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_lock_vc <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_vc <= w_lock_nxt;
            if (w_grant) r_rr_ptr <= w_grant_vc + 1'b1;
        end
    end

    // Registered router-side output flit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            r_flits_out <= '0;
            r_vc_out    <= '0;
            r_tail_out  <= 1'b0;
        end else begin
            r_valid_out <= w_grant;
            if (w_grant) begin
                r_flits_out <= w_inj_head[DATA_WIDTH-1:0];
                r_tail_out  <= w_inj_head[DATA_WIDTH];
                r_vc_out    <= w_grant_vc;
            end
        end
    end

    // Registered core-side ejected flit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_valid_out <= 1'b0;
            core_data_out  <= '0;
        end else begin
            core_valid_out <= |w_ej_pop;
            if (|w_ej_pop) core_data_out <= w_ej_head;
        end
    end

`ifdef NOC_ADAPTER_STATS_EN
    // Saturating traffic counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_count <= 16'h0000;
            ej_count  <= 16'h0000;
        end else begin
            if (w_grant && (inj_count != 16'hFFFF)) inj_count <= inj_count + 16'd1;
            if ((|w_ej_pop) && (ej_count != 16'hFFFF)) ej_count <= ej_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_core_adapter.sv
// Self-checking bench for noc_core_adapter: directed vector table, hand-built
// corner sequences and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_noc_core_adapter;

    localparam int DW    = 32;
    localparam int VB    = 1;
    localparam int NV    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          c_WEn = 1'b0;
    logic [DW-1:0] core_data_in = '0;
    logic [VB-1:0] core_vc_in = '0;
    logic          core_tail_in = 1'b0;
    logic [NV-1:0] core_full_out;
    logic [DW-1:0] r_flits_out;
    logic [VB-1:0] r_vc_out;
    logic          r_tail_out;
    logic          r_valid_out;
    logic [NV-1:0] r_full_in = '0;
    logic [DW-1:0] r_flits_in = '0;
    logic [VB-1:0] r_vc_in = '0;
    logic          r_valid_in = 1'b0;
    logic [NV-1:0] r_full_out;
    logic          c_REn = 1'b0;
    logic [VB-1:0] core_vc_sel = '0;
    logic [DW-1:0] core_data_out;
    logic          core_valid_out;
    logic [NV-1:0] core_empty_out;
`ifdef NOC_ADAPTER_STATS_EN
    logic [15:0]   inj_count;
    logic [15:0]   ej_count;
`endif

    noc_core_adapter #(.DATA_WIDTH(DW), .VC_BITS(VB), .FIFO_DEPTH_BITS(2)) dut (
        .clk(clk), .reset(reset),
        .c_WEn(c_WEn), .core_data_in(core_data_in), .core_vc_in(core_vc_in),
        .core_tail_in(core_tail_in), .core_full_out(core_full_out),
        .r_flits_out(r_flits_out), .r_vc_out(r_vc_out), .r_tail_out(r_tail_out),
        .r_valid_out(r_valid_out), .r_full_in(r_full_in),
        .r_flits_in(r_flits_in), .r_vc_in(r_vc_in), .r_valid_in(r_valid_in),
        .r_full_out(r_full_out), .c_REn(c_REn), .core_vc_sel(core_vc_sel),
        .core_data_out(core_data_out), .core_valid_out(core_valid_out),
        .core_empty_out(core_empty_out)
`ifdef NOC_ADAPTER_STATS_EN
        , .inj_count(inj_count), .ej_count(ej_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model (packet-level queues) ----------------
    logic [DW:0]   inj_q [NV][$];
    logic [DW-1:0] ej_q  [NV][$];
    bit            m_locked;
    int            m_lock;
    int            m_last;
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [VB-1:0] m_rvc;
    bit            m_rtail;
    bit            m_cvalid;
    logic [DW-1:0] m_cdata;
    int            m_inj_n;
    int            m_ej_n;

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            inj_q[v].delete();
            ej_q[v].delete();
        end
        m_locked = 1'b0;
        m_lock   = 0;
        m_last   = NV - 1;   // next search starts at VC0
        m_rvalid = 1'b0;
        m_cvalid = 1'b0;
        m_inj_n  = 0;
        m_ej_n   = 0;
    endfunction

    // One clock of the adapter's behaviour, using the inputs at the edge
    function automatic void model_step();
        int g;
        logic [DW:0] f;
        g = -1;
        if (m_locked) begin
            if (inj_q[m_lock].size() > 0 && !r_full_in[m_lock]) g = m_lock;
        end else begin
            for (int k = 1; k <= NV; k++) begin
                int v;
                v = (m_last + k) % NV;
                if (g < 0 && inj_q[v].size() > 0 && !r_full_in[v]) g = v;
            end
        end
        if (g >= 0) begin
            f        = inj_q[g].pop_front();
            m_rvalid = 1'b1;
            m_rdata  = f[DW-1:0];
            m_rtail  = f[DW];
            m_rvc    = VB'(g);
            m_last   = g;
            m_lock   = g;
            m_locked = !f[DW];
            if (m_inj_n < 65535) m_inj_n++;
        end else begin
            m_rvalid = 1'b0;
        end
        if (c_WEn && inj_q[core_vc_in].size() < DEPTH)
            inj_q[core_vc_in].push_back({core_tail_in, core_data_in});
        if (c_REn && ej_q[core_vc_sel].size() > 0) begin
            m_cvalid = 1'b1;
            m_cdata  = ej_q[core_vc_sel].pop_front();
            if (m_ej_n < 65535) m_ej_n++;
        end else begin
            m_cvalid = 1'b0;
        end
        if (r_valid_in && ej_q[r_vc_in].size() < DEPTH)
            ej_q[r_vc_in].push_back(r_flits_in);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [NV-1:0] ef, ejf, eje;
        for (int v = 0; v < NV; v++) begin
            ef[v]  = (inj_q[v].size() == DEPTH);
            ejf[v] = (ej_q[v].size() == DEPTH);
            eje[v] = (ej_q[v].size() == 0);
        end
        chk("r_valid_out", 64'(r_valid_out), 64'(m_rvalid));
        if (m_rvalid) begin
            chk("r_flits_out", 64'(r_flits_out), 64'(m_rdata));
            chk("r_vc_out", 64'(r_vc_out), 64'(m_rvc));
            chk("r_tail_out", 64'(r_tail_out), 64'(m_rtail));
        end
        chk("core_valid_out", 64'(core_valid_out), 64'(m_cvalid));
        if (m_cvalid) chk("core_data_out", 64'(core_data_out), 64'(m_cdata));
        chk("core_full_out", 64'(core_full_out), 64'(ef));
        chk("r_full_out", 64'(r_full_out), 64'(ejf));
        chk("core_empty_out", 64'(core_empty_out), 64'(eje));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        c_WEn = 1'b0; r_valid_in = 1'b0; c_REn = 1'b0; r_full_in = '0;
    endtask

    task automatic wr(input logic [VB-1:0] vc, input logic tl, input logic [DW-1:0] d);
        c_WEn = 1'b1; core_vc_in = vc; core_tail_in = tl; core_data_in = d;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          we;
        logic [VB-1:0] vc;
        logic          tl;
        logic [DW-1:0] d;
        logic [NV-1:0] fin;
        logic          ev;
        logic [VB-1:0] evc;
        logic          et;
        logic [DW-1:0] ed;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic we, input logic [VB-1:0] vc, input logic tl,
                       input logic [DW-1:0] d, input logic [NV-1:0] fin,
                       input logic ev, input logic [VB-1:0] evc, input logic et,
                       input logic [DW-1:0] ed);
        vec_t r;
        r.we = we; r.vc = vc; r.tl = tl; r.d = d; r.fin = fin;
        r.ev = ev; r.evc = evc; r.et = et; r.ed = ed;
        vq.push_back(r);
    endtask

    initial begin
        // 3-flit packet on VC0
        add(1'b1, 1'b0, 1'b0, 32'hA1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 1'b0, 32'hA2, 2'b00, 1'b1, 1'b0, 1'b0, 32'hA1);
        add(1'b1, 1'b0, 1'b1, 32'hA3, 2'b00, 1'b1, 1'b0, 1'b0, 32'hA2);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 1'b0, 1'b1, 32'hA3);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        // VC0 blocked by router: VC1 overtakes, then VC0 packet
        add(1'b1, 1'b0, 1'b0, 32'hB1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b1, 1'b1, 32'hC1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 1'b1, 32'hB2, 2'b01, 1'b1, 1'b1, 1'b1, 32'hC1);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 1'b0, 1'b0, 32'hB1);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 1'b0, 1'b1, 32'hB2);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        // VC0 blocked mid-packet with VC1 waiting: VC0 still finishes first
        add(1'b1, 1'b0, 1'b0, 32'hD1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b1, 1'b1, 32'hE1, 2'b00, 1'b1, 1'b0, 1'b0, 32'hD1);
        add(1'b1, 1'b0, 1'b0, 32'hD2, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 1'b1, 32'hD3, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 1'b0, 1'b0, 32'hD2);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 1'b0, 1'b1, 32'hD3);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 1'b1, 1'b1, 1'b1, 32'hE1);
        add(1'b0, 1'b0, 1'b0, 32'h0,  2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

        // reset state
        model_reset();
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst r_valid_out", 64'(r_valid_out), 64'd0);
        chk("rst r_flits_out", 64'(r_flits_out), 64'd0);
        chk("rst r_vc_out", 64'(r_vc_out), 64'd0);
        chk("rst r_tail_out", 64'(r_tail_out), 64'd0);
        chk("rst core_valid_out", 64'(core_valid_out), 64'd0);
        chk("rst core_data_out", 64'(core_data_out), 64'd0);
        chk("rst core_empty_out", 64'(core_empty_out), 64'h3);
        chk("rst core_full_out", 64'(core_full_out), 64'd0);
        chk("rst r_full_out", 64'(r_full_out), 64'd0);
        reset = 1'b0;

        // table
        foreach (vq[i]) begin
            c_WEn = vq[i].we; core_vc_in = vq[i].vc; core_tail_in = vq[i].tl;
            core_data_in = vq[i].d; r_full_in = vq[i].fin;
            step();
            chk($sformatf("vec%0d valid", i), 64'(r_valid_out), 64'(vq[i].ev));
            if (vq[i].ev) begin
                chk($sformatf("vec%0d vc", i), 64'(r_vc_out), 64'(vq[i].evc));
                chk($sformatf("vec%0d tail", i), 64'(r_tail_out), 64'(vq[i].et));
                chk($sformatf("vec%0d data", i), 64'(r_flits_out), 64'(vq[i].ed));
            end
        end
        idle_inputs();

        // ejection FIFO overflow: 5 pushes into 4 slots, then read back
        for (int k = 1; k <= 5; k++) begin
            r_valid_in = 1'b1; r_vc_in = 1'b1; r_flits_in = DW'(k);
            step();
            if (k >= 4) chk("ej full after 4", 64'(r_full_out), 64'h2);
        end
        r_valid_in = 1'b0;
        c_REn = 1'b1; core_vc_sel = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("ej read valid", 64'(core_valid_out), 64'd1);
            chk("ej read data", 64'(core_data_out), 64'(k));
        end
        step();
        chk("ej read empty valid", 64'(core_valid_out), 64'd0);
        chk("ej read empty flag", 64'(core_empty_out), 64'h3);
        idle_inputs();

        // reset while locked on VC0 with FIFOs partly filled
        wr(1'b0, 1'b0, 32'h51); step();
        wr(1'b0, 1'b0, 32'h52); step();
        wr(1'b1, 1'b0, 32'h61); step();
        wr(1'b0, 1'b0, 32'h53); r_valid_in = 1'b1; r_vc_in = 1'b0; r_flits_in = 32'h71; step();
        wr(1'b1, 1'b0, 32'h62); r_flits_in = 32'h72; step();
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        chk("async rst r_valid_out", 64'(r_valid_out), 64'd0);
        chk("async rst core_valid_out", 64'(core_valid_out), 64'd0);
        chk("async rst core_empty_out", 64'(core_empty_out), 64'h3);
        chk("async rst core_full_out", 64'(core_full_out), 64'd0);
        chk("async rst r_full_out", 64'(r_full_out), 64'd0);
        chk("async rst r_flits_out", 64'(r_flits_out), 64'd0);
        model_reset();
        #1 reset = 1'b0;
        r_full_in = 2'b11;
        wr(1'b1, 1'b1, 32'h81); step();
        wr(1'b0, 1'b1, 32'h91); step();
        c_WEn = 1'b0; r_full_in = 2'b00; step();
        chk("post-rst first vc", 64'(r_vc_out), 64'd0);
        chk("post-rst first data", 64'(r_flits_out), 64'h91);
        step();
        chk("post-rst second vc", 64'(r_vc_out), 64'd1);
        chk("post-rst second data", 64'(r_flits_out), 64'h81);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            c_WEn        = ($urandom_range(0, 99) < 60);
            core_vc_in   = VB'($urandom_range(0, NV - 1));
            core_tail_in = ($urandom_range(0, 2) == 0);
            core_data_in = $urandom;
            for (int v = 0; v < NV; v++) r_full_in[v] = ($urandom_range(0, 9) < 3);
            r_valid_in   = ($urandom_range(0, 99) < 50);
            r_vc_in      = VB'($urandom_range(0, NV - 1));
            r_flits_in   = $urandom;
            c_REn        = ($urandom_range(0, 99) < 40);
            core_vc_sel  = VB'($urandom_range(0, NV - 1));
            step();
            if (i == 1500) begin
                #2 reset = 1'b1;
                #1;
                model_reset();
                check_all();
                #1 reset = 1'b0;
            end
        end
        idle_inputs();
        step();

`ifdef NOC_ADAPTER_STATS_EN
        chk("inj_count", 64'(inj_count), 64'(m_inj_n));
        chk("ej_count", 64'(ej_count), 64'(m_ej_n));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
